// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM and
// hands {inst, pc} to decode, with a one-entry buffer that absorbs decode back-pressure.
module if_stage #(
   parameter logic [31:0] RESET_PC       = 32'h1c000000,
   parameter int unsigned BR_BUS_W       = 33,
   parameter int unsigned FS_TO_DS_BUS_W = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ds_allowin,
   input  logic [BR_BUS_W-1:0]       br_bus,
   output logic                      fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
   output logic                      inst_sram_en,
   output logic                      inst_sram_we,
   output logic [31:0]               inst_sram_addr,
   output logic [31:0]               inst_sram_wdata,
   input  logic [31:0]               inst_sram_rdata
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic            fs_valid_q, fs_valid_d;
   logic [XLEN-1:0] fs_pc_q, fs_pc_d;
   logic [XLEN-1:0] inst_buf_q, inst_buf_d;
   logic            inst_buf_valid_q, inst_buf_valid_d;
   logic            rdata_fresh_q, rdata_fresh_d;

   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            to_fs_valid;
   logic            fs_ready_go;
   logic            fs_allowin;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] nextpc;
   logic [XLEN-1:0] fs_inst;
   logic            buf_capture;

   // Pre-IF: next-PC selection; a taken branch overrides the sequential path
   assign br_taken    = br_bus[XLEN];
   assign br_target   = br_bus[XLEN-1:0];
   assign to_fs_valid = ~reset;
   assign seq_pc      = fs_pc_q + PC_STEP;
   assign nextpc      = br_taken ? br_target : seq_pc;

   // A squashed IF instruction never blocks the redirect fetch
   assign fs_ready_go = 1'b1;
   assign fs_allowin  = ~fs_valid_q | ds_allowin | br_taken;

   assign inst_sram_en    = to_fs_valid & fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = '0;

   // Read data is only trustworthy the cycle after an enabled read, so capture it then
   assign buf_capture = fs_valid_q & rdata_fresh_q & ~ds_allowin & ~br_taken;
   assign fs_inst     = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;

   assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~br_taken & to_fs_valid;
   assign fs_to_ds_bus   = FS_TO_DS_BUS_W'({fs_inst, fs_pc_q});

   // Next-state: advance on fetch, otherwise hold and possibly capture stalled data
   always_comb begin
      fs_valid_d       = fs_valid_q;
      fs_pc_d          = fs_pc_q;
      inst_buf_d       = inst_buf_q;
      inst_buf_valid_d = inst_buf_valid_q;
      rdata_fresh_d    = 1'b0;
      if (to_fs_valid && fs_allowin) begin
         fs_valid_d       = 1'b1;
         fs_pc_d          = nextpc;
         inst_buf_valid_d = 1'b0;
         rdata_fresh_d    = inst_sram_en;
      end else if (buf_capture) begin
         inst_buf_d       = inst_sram_rdata;
         inst_buf_valid_d = 1'b1;
      end
   end

   // State register; reset parks the PC one word below RESET_PC so the first fetch hits it
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid_q       <= 1'b0;
         fs_pc_q          <= RESET_PC - PC_STEP;
         inst_buf_q       <= '0;
         inst_buf_valid_q <= 1'b0;
         rdata_fresh_q    <= 1'b0;
      end else begin
         fs_valid_q       <= fs_valid_d;
         fs_pc_q          <= fs_pc_d;
         inst_buf_q       <= inst_buf_d;
         inst_buf_valid_q <= inst_buf_valid_d;
         rdata_fresh_q    <= rdata_fresh_d;
      end
   end

endmodule
